// File: rtl/seq_muldiv_unit.sv
// Multi-cycle unsigned WIDTHxWIDTH multiply / WIDTH/WIDTH restoring divide.
// The unit iterates one bit per clock and drives a one-cycle done pulse with a registered 2*WIDTH result.
module seq_muldiv_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     sum, mul_acc, shl, trial;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // hi holds the product upper half (multiply) or the partial remainder (divide);
  // lo holds the shifting multiplier (multiply) or dividend/quotient bits (divide).
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    sum     = {1'b0, hi_q} + {1'b0, opb_q};
    mul_acc = lo_q[0] ? sum : {1'b0, hi_q};
    shl     = {hi_q, lo_q[WIDTH-1]};
    trial   = shl - {1'b0, opb_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          op_d    = op;
          opb_d   = b;
          hi_d    = '0;
          lo_d    = a;
          cnt_d   = '0;
          dbz_d   = 1'b0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (!op_q) begin
          hi_d = mul_acc[WIDTH:1];
          lo_d = {mul_acc[0], lo_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
          hi_d = trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shl[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        // A zero divisor never fails the trial subtract, so the restoring loop
        // naturally yields quotient all-ones and remainder equal to the dividend.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = {hi_d, lo_d};
          dbz_d    = op_q && (opb_q == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign result      = result_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit: hand-computed results, cycle-exact busy/done timing,
// ignored starts while busy, div-by-zero flag lifetime and asynchronous mid-operation reset.
module tb_seq_muldiv_unit;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [15:0] result;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        dbz_prev = 1'b0;
  logic [15:0] res_prev = 16'h0000;

  seq_muldiv_unit #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an operation on the first negedge (expected to be an IDLE cycle) and checks
  // every cycle through done. With scramble set, start and operands are re-driven randomly
  // throughout CALC and DONE; the DUT must ignore them.
  task automatic run_op(input logic op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic [15:0] exp_res, input logic exp_dbz, input logic scramble);
    @(negedge clock);
    chk("idle_busy", 16'(busy), 16'h0);
    chk("idle_done", 16'(done), 16'h0);
    chk("dbz_hold", 16'(div_by_zero), 16'(dbz_prev));
    op = op_v; a = a_v; b = b_v; start = 1'b1;
    @(posedge clock);
    #1;
    if (!scramble) start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      chk("calc_busy", 16'(busy), 16'h1);
      chk("calc_done", 16'(done), 16'h0);
      if (k == 1) chk("dbz_clear_on_start", 16'(div_by_zero), 16'h0);
      if (k == 4) chk("result_held_in_calc", result, res_prev);
      if (scramble) begin
        op = 1'($urandom); a = 8'($urandom); b = 8'($urandom); start = 1'b1;
      end
    end
    @(negedge clock);
    chk("done_pulse", 16'(done), 16'h1);
    chk("done_busy", 16'(busy), 16'h0);
    chk("result", result, exp_res);
    chk("dbz", 16'(div_by_zero), 16'(exp_dbz));
    @(posedge clock);
    #1;
    start    = 1'b0;
    dbz_prev = exp_dbz;
    res_prev = exp_res;
  endtask

  initial begin
    int pulses;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_dbz", 16'(div_by_zero), 16'h0);
    chk("rst_result", result, 16'h0000);
    reset_n = 1'b1;

    run_op(1'b0, 8'd13,  8'd11,  16'h008F, 1'b0, 1'b0);
    run_op(1'b0, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0);
    run_op(1'b0, 8'd0,   8'd200, 16'h0000, 1'b0, 1'b0);
    run_op(1'b1, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0);
    run_op(1'b1, 8'd5,   8'd9,   16'h0500, 1'b0, 1'b0);
    run_op(1'b1, 8'h2A,  8'd0,   16'h2AFF, 1'b1, 1'b0);
    // Flag held through idle, cleared on the next accepted start (checked inside run_op).
    run_op(1'b0, 8'd100, 8'd3,   16'h012C, 1'b0, 1'b1);
    run_op(1'b1, 8'd250, 8'd16,  16'h0A0F, 1'b0, 1'b0);
    run_op(1'b1, 8'd0,   8'd0,   16'h00FF, 1'b1, 1'b0);

    // Asynchronous reset during the 4th CALC cycle.
    @(negedge clock);
    op = 1'b0; a = 8'd77; b = 8'd91; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("pre_rst_busy", 16'(busy), 16'h1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy", 16'(busy), 16'h0);
    chk("async_rst_done", 16'(done), 16'h0);
    chk("async_rst_dbz", 16'(div_by_zero), 16'h0);
    chk("async_rst_result", result, 16'h0000);
    #4;
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    chk("no_done_after_rst", 16'(pulses), 16'h0);
    dbz_prev = 1'b0;
    res_prev = 16'h0000;
    run_op(1'b0, 8'd6, 8'd7, 16'h002A, 1'b0, 1'b0);

    @(negedge clock);
    chk("final_idle_busy", 16'(busy), 16'h0);
    chk("final_idle_done", 16'(done), 16'h0);
    chk("final_result_held", result, 16'h002A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
